// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; optional launch timeout via `UART_ARB_TIMEOUT_EN.
// 2 cycles req_valid->tx_en; requesters hold valid until a 1-cycle req_ready, frames paced by tx_busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [10:0]                   cfg_in,
  output logic [10:0]                   cfg_out,
  output logic                          tx_en,
  output logic [DATA_WIDTH-1:0]         tx_din,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          active,
  output logic                          tx_err
);

  localparam int GW = $clog2(NUM_REQ);

  typedef struct packed {
    logic [2:0] bps_mode;
    logic [3:0] data_num;
    logic [1:0] check_mode;
    logic [1:0] stop_num;
  } cfg_t;

  localparam cfg_t CFG_RST = cfg_t'(11'h074);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LAUNCH,
    S_SEND,
    S_DONE
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  state_t          state;
  cfg_t            cfg_q;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   rr_idx;
  logic            found;
  int              rr_sum;

  assign cfg_out = cfg_q;

  // Search starts one past the last served requester so nobody starves.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    rr_sum = 0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = int'(last_grant) + k;
      if (rr_sum >= NUM_REQ) rr_sum = rr_sum - NUM_REQ;
      rr_idx = GW'(rr_sum);
      if (!found && req_valid[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] tout_cnt;
`else
  assign tx_err = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state      <= S_IDLE;
      tx_en      <= 1'b0;
      tx_din     <= '0;
      req_ready  <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      active     <= 1'b0;
      cfg_q      <= CFG_RST;
`ifdef UART_ARB_TIMEOUT_EN
      tx_err     <= 1'b0;
      tout_cnt   <= '0;
`endif
    end else begin
      req_ready <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      tx_err    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // Config only follows cfg_in between frames.
          cfg_q <= cfg_in;
          if (|req_valid) begin
            grant_id  <= winner;
            req_ready <= NUM_REQ'(1) << winner;
            active    <= 1'b1;
            state     <= S_ARB;
          end
        end
        S_ARB: begin
          tx_din <= req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
          tx_en  <= 1'b1;
          state  <= S_LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
          tout_cnt <= '0;
`endif
        end
        S_LAUNCH: begin
          if (tx_busy) begin
            state <= S_SEND;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (tout_cnt == CW'(TIMEOUT_CYC - 1)) begin
            tx_en  <= 1'b0;
            tx_err <= 1'b1;
            state  <= S_DONE;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
          end
`endif
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_en <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          last_grant <= grant_id;
          active     <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          tx_en  <= 1'b0;
          active <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: frame table plus reset, config and timeout sequences.
module tb_uart_tx_arbiter;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [10:0] cfg_in;
  logic [10:0] cfg_out;
  logic        tx_en;
  logic [15:0] tx_din;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        tx_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] exp_cfg;
  logic err_seen = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .TIMEOUT_CYC(16)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cfg_in    (cfg_in),
    .cfg_out   (cfg_out),
    .tx_en     (tx_en),
    .tx_din    (tx_din),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .tx_err    (tx_err)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) if (tx_err !== 1'b0) err_seen = 1'b1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] dat;
    logic [1:0]  gnt;
    int          dly;
    int          len;
    logic        keep;
    logic        pre;
    logic        mid;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left on a negedge with the DUT in IDLE.
  task automatic run_frame(input vec_t v);
    int   rdy_cnt;
    logic en_ok;
    logic cfg_ok;
    rdy_cnt = 0;
    en_ok   = 1'b1;
    cfg_ok  = 1'b1;
    check("idle_active", active, 0);
    req_valid = v.vld;
    for (int i = 0; i < 4; i++)
      req_data[i*16 +: 16] = (i == int'(v.gnt)) ? v.dat : (16'hDE00 | 16'(i));
    tx_busy = v.pre;
    @(negedge pclk);
    check("arb_grant", grant_id, v.gnt);
    check("arb_ready", req_ready, 4'b0001 << v.gnt);
    check("arb_tx_en", tx_en, 0);
    rdy_cnt += $countones(req_ready);
    if (!v.keep) req_valid[v.gnt] = 1'b0;
    @(negedge pclk);
    check("launch_tx_en", tx_en, 1);
    check("launch_tx_din", tx_din, v.dat);
    rdy_cnt += $countones(req_ready);
    repeat (v.dly) begin
      @(negedge pclk);
      en_ok &= tx_en;
      rdy_cnt += $countones(req_ready);
    end
    tx_busy = 1'b1;
    repeat (v.len) begin
      @(negedge pclk);
      en_ok &= tx_en;
      cfg_ok &= (cfg_out == exp_cfg);
      rdy_cnt += $countones(req_ready);
      if (v.mid) cfg_in = 11'h2B1;
    end
    tx_busy = 1'b0;
    @(negedge pclk);
    check("frame_tx_en_held", en_ok, 1);
    check("frame_cfg_held", cfg_ok, 1);
    check("done_tx_en", tx_en, 0);
    check("done_active", active, 1);
    check("done_grant", grant_id, v.gnt);
    check("done_tx_din", tx_din, v.dat);
    check("done_cfg", cfg_out, exp_cfg);
    rdy_cnt += $countones(req_ready);
    @(negedge pclk);
    check("gap_tx_en", tx_en, 0);
    check("gap_active", active, 0);
    check("gap_cfg", cfg_out, exp_cfg);
    rdy_cnt += $countones(req_ready);
    check("ready_pulses", rdy_cnt, 1);
  endtask

  initial begin
    vec_t v;
    logic ok;
    presetn   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    cfg_in    = 11'h0F4;
    exp_cfg   = 11'h0F4;

    tbl[0]  = '{4'b0100, 16'hA5C3, 2'd2, 3, 100, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 16'h1234, 2'd2, 1, 3,   1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'b1011, 16'h3333, 2'd3, 2, 2,   1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'b1011, 16'h0F0F, 2'd0, 1, 1,   1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'b1011, 16'h1111, 2'd1, 0, 2,   1'b0, 1'b0, 1'b0};
    tbl[5]  = '{4'b1011, 16'hBEEF, 2'd3, 1, 2,   1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[6+i] = '{4'b1111, 16'h6000 + 16'(i), 2'(i % 4), 1, 2, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{4'b0001, 16'hC0DE, 2'd0, 0, 3,   1'b0, 1'b1, 1'b0};
    tbl[15] = '{4'b1000, 16'h8001, 2'd3, 1, 2,   1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge pclk);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_din", tx_din, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant", grant_id, 0);
    check("rst_active", active, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_cfg", cfg_out, 11'h074);
    presetn = 1'b1;
    @(negedge pclk);
    check("idle_cfg_load", cfg_out, 11'h0F4);

    for (int i = 0; i < 16; i++) run_frame(tbl[i]);

    // Config change while the frame is in SEND lands only after DONE.
    v = '{4'b0001, 16'h5A5A, 2'd0, 1, 4, 1'b0, 1'b0, 1'b1};
    run_frame(v);
    @(negedge pclk);
    check("cfg_new_after_idle", cfg_out, 11'h2B1);
    exp_cfg = 11'h2B1;

    // Reset in the middle of a frame for requester 1.
    req_valid = 4'b0010;
    @(negedge pclk);
    check("mid_rst_arb_grant", grant_id, 1);
    req_valid = 4'b0000;
    @(negedge pclk);
    tx_busy = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    check("mid_rst_send_tx_en", tx_en, 1);
    presetn = 1'b0;
    @(negedge pclk);
    check("mid_rst_tx_en", tx_en, 0);
    check("mid_rst_active", active, 0);
    check("mid_rst_cfg", cfg_out, 11'h074);
    check("mid_rst_grant", grant_id, 0);
    check("mid_rst_tx_din", tx_din, 0);
    presetn = 1'b1;
    tx_busy = 1'b0;
    v = '{4'b1111, 16'h7777, 2'd0, 1, 2, 1'b0, 1'b0, 1'b0};
    run_frame(v);

`ifdef UART_ARB_TIMEOUT_EN
    req_valid = 4'b0011;
    req_data  = 64'h0000_0000_1010_2020;
    @(negedge pclk);
    check("to_arb_grant", grant_id, 1);
    @(negedge pclk);
    ok = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge pclk);
      ok &= (tx_err == 1'b0) && (tx_en == 1'b1);
    end
    check("to_wait_quiet", ok, 1);
    @(negedge pclk);
    check("to_tx_err", tx_err, 1);
    check("to_done_tx_en", tx_en, 0);
    check("to_done_active", active, 1);
    @(negedge pclk);
    check("to_err_one_cycle", tx_err, 0);
    v = '{4'b0011, 16'h2468, 2'd0, 1, 2, 1'b0, 1'b0, 1'b0};
    run_frame(v);
`else
    ok = 1'b1;
    check("tx_err_tied_low", err_seen, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
